link_ctrl_8b10b: RTL and testbench

//  Supervisor for the serial 8b10b decoder: owns the decoder's reset, waits for K.28.5 lock, re-pulses
//  the decoder on lock timeout or on a resync request, and counts lock losses. Decoded bytes go into a

---
 rtl/link_ctrl_8b10b_pkg.sv | 19 +
 rtl/link_ctrl_8b10b_if.sv | 13 +
 rtl/link_ctrl_8b10b_byte_fifo.sv | 52 +++++
 rtl/link_ctrl_8b10b.sv | 151 +++++++++++++++
 tb/tb_link_ctrl_8b10b.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/link_ctrl_8b10b_pkg.sv
// Shared types and helpers for the 8b10b link supervisor.
//   state_t : supervisor FSM states (HOLD / SEARCH / LOCKED)
//   CNT_W   : width of the status counters
//   sat_inc : increment that sticks at all-ones
package link_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int CNT_W = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/link_ctrl_8b10b_if.sv
// Byte stream from the link supervisor's FIFO to the protocol logic.
//   m_data  : head byte
//   m_valid : head byte present
//   m_ready : consumer takes the head when m_valid && m_ready
// master = producer (link_ctrl_8b10b), slave = consumer.
interface link_ctrl_8b10b_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/link_ctrl_8b10b_byte_fifo.sv
// Synchronous FIFO, first-word-fall-through read.
//   clk, rst_n : clock, synchronous active-low reset (flushes the FIFO)
//   push       : write wr_data; accepted when not full, or when full and popping
//   pop        : discard head; caller only pops when !empty
//   rd_data    : head entry
//   full/empty : occupancy flags
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty when the
  // address bits match.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en, rd_en;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  // On full, a same-cycle pop frees the head slot, which the write reuses.
  assign wr_en   = push && (!full || pop);
  assign rd_en   = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define
  // which entries are meaningful, and resetting the array costs muxes.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/link_ctrl_8b10b.sv
// Supervisor for a serial 8b10b decoder.
// Holds the decoder in reset, waits for framing lock, re-resets it on a
// search timeout or a resync request, and buffers decoded bytes for a
// valid/ready consumer.
//   clk, rst_n   : clock, synchronous active-low reset
//   dec_rst_n    : registered active-low reset to the decoder
//   dec_valid    : decoder framing lock
//   dec_data     : decoder byte, new when dec_updated pulses
//   resync_req   : force a decoder reset and re-lock (ignored in HOLD)
//   clr_status   : clear loss_cnt, timeout_cnt, overflow
//   m_if         : byte stream out (m_data / m_valid / m_ready)
//   link_up      : registered, high while LOCKED
//   loss_cnt     : saturating count of LOCKED->SEARCH transitions
//   timeout_cnt  : saturating count of SEARCH timeouts
//   overflow     : sticky, a locked byte was dropped on a full FIFO
module link_ctrl_8b10b
  import link_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = 4,
  parameter int SEARCH_TIMEOUT = 200,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                dec_rst_n,
  input  logic                dec_valid,
  input  logic [7:0]          dec_data,
  input  logic                dec_updated,
  input  logic                resync_req,
  input  logic                clr_status,
  link_ctrl_8b10b_if.master   m_if,
  output logic                link_up,
  output logic [CNT_W-1:0]    loss_cnt,
  output logic [CNT_W-1:0]    timeout_cnt,
  output logic                overflow
);

  localparam int TMR_MAX = (RST_CYCLES > SEARCH_TIMEOUT) ? RST_CYCLES : SEARCH_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX);

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               loss_inc, timeout_inc;

  logic               push, pop, drop;
  logic               fifo_full, fifo_empty;
  logic [7:0]         fifo_head;
  logic [CNT_W-1:0]   loss_base, timeout_base;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    loss_inc    = 1'b0;
    timeout_inc = 1'b0;

    // A resync request outranks lock, loss and timeout in the same cycle.
    if (resync_req && state != HOLD) begin
      state_nxt = HOLD;
      timer_nxt = '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (timer == TMR_W'(RST_CYCLES - 1)) begin
            state_nxt = SEARCH;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        SEARCH: begin
          if (dec_valid) begin
            state_nxt = LOCKED;
            timer_nxt = '0;
          end else if (timer == TMR_W'(SEARCH_TIMEOUT - 1)) begin
            state_nxt   = HOLD;
            timer_nxt   = '0;
            timeout_inc = 1'b1;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        LOCKED: begin
          // The decoder re-acquires on its own, so loss goes to SEARCH
          // without another reset pulse.
          if (!dec_valid) begin
            state_nxt = SEARCH;
            timer_nxt = '0;
            loss_inc  = 1'b1;
          end
        end
        default: begin
          state_nxt = HOLD;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // Only bytes decoded under lock are kept; anything else is silently
  // discarded and does not count as overflow.
  assign push = dec_updated && (state == LOCKED) && dec_valid;
  assign pop  = m_if.m_valid && m_if.m_ready;
  assign drop = push && fifo_full && !pop;

  // Clear first, then apply the event, so a same-cycle event survives.
  assign loss_base    = clr_status ? '0 : loss_cnt;
  assign timeout_base = clr_status ? '0 : timeout_cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HOLD;
      timer       <= '0;
      dec_rst_n   <= 1'b0;
      link_up     <= 1'b0;
      loss_cnt    <= '0;
      timeout_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      // Registered alongside the state so they never disagree with it.
      dec_rst_n   <= (state_nxt != HOLD);
      link_up     <= (state_nxt == LOCKED);
      loss_cnt    <= loss_inc    ? sat_inc(loss_base)    : loss_base;
      timeout_cnt <= timeout_inc ? sat_inc(timeout_base) : timeout_base;
      overflow    <= drop | (overflow & ~clr_status);
    end
  end

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (dec_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_if.m_data  = fifo_head;
  assign m_if.m_valid = !fifo_empty;

endmodule

// File: tb/tb_link_ctrl_8b10b.sv
// Directed bench for link_ctrl_8b10b with default parameters
// (RST_CYCLES=4, SEARCH_TIMEOUT=200, FIFO_DEPTH=4). The decoder is modelled
// by driving dec_valid / dec_data / dec_updated directly.
module tb_link_ctrl_8b10b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_rst_n;
  logic       dec_valid;
  logic [7:0] dec_data;
  logic       dec_updated;
  logic       resync_req;
  logic       clr_status;
  logic       link_up;
  logic [7:0] loss_cnt;
  logic [7:0] timeout_cnt;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int n;
  logic up;

  link_ctrl_8b10b_if bus ();

  link_ctrl_8b10b dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_rst_n   (dec_rst_n),
    .dec_valid   (dec_valid),
    .dec_data    (dec_data),
    .dec_updated (dec_updated),
    .resync_req  (resync_req),
    .clr_status  (clr_status),
    .m_if        (bus.master),
    .link_up     (link_up),
    .loss_cnt    (loss_cnt),
    .timeout_cnt (timeout_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count consecutive samples (one per cycle, starting now) with dec_rst_n
  // at lvl, bounded by limit; also reports whether link_up was ever seen high.
  task automatic count_level(input logic lvl, input int limit, output int cnt, output logic saw_up);
    cnt    = 0;
    saw_up = 1'b0;
    while (dec_rst_n === lvl && cnt < limit) begin
      saw_up = saw_up | link_up;
      cnt++;
      tick();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    dec_valid   = 1'b0;
    dec_data    = 8'h00;
    dec_updated = 1'b0;
    resync_req  = 1'b0;
    clr_status  = 1'b0;
    bus.m_ready = 1'b0;

    // ---- 1: reset and first decoder reset pulse
    repeat (3) tick();
    check("rst_dec_rst_n", 32'(dec_rst_n), 0);
    check("rst_link_up", 32'(link_up), 0);
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_loss_cnt", 32'(loss_cnt), 0);
    check("rst_timeout_cnt", 32'(timeout_cnt), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    count_level(1'b0, 50, n, up);
    check("t1_hold_cycles", 32'(n), 4);
    check("t1_link_up_in_hold", 32'(up), 0);
    check("t1_link_up_search", 32'(link_up), 0);

    // ---- 2: lock and two bytes, consumer always ready
    bus.m_ready = 1'b1;
    dec_valid   = 1'b1;
    tick();
    check("t2_link_up", 32'(link_up), 1);
    dec_data    = 8'hB5;
    dec_updated = 1'b1;
    tick();
    check("t2_b5_valid", 32'(bus.m_valid), 1);
    check("t2_b5_data", 32'(bus.m_data), 'hB5);
    dec_data = 8'h00;
    tick();
    check("t2_00_valid", 32'(bus.m_valid), 1);
    check("t2_00_data", 32'(bus.m_data), 'h00);
    dec_updated = 1'b0;
    tick();
    check("t2_drained", 32'(bus.m_valid), 0);

    // ---- 4: overflow with stalled consumer
    bus.m_ready = 1'b0;
    dec_updated = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dec_data = 8'(8'h10 + i);
      tick();
      if (i == 3) check("t4_no_ovf_when_just_full", 32'(overflow), 0);
    end
    dec_updated = 1'b0;
    check("t4_overflow", 32'(overflow), 1);
    check("t4_head_valid", 32'(bus.m_valid), 1);
    check("t4_head_data", 32'(bus.m_data), 'h10);
    tick();
    check("t4_head_stable", 32'(bus.m_data), 'h10);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_valid", 32'(bus.m_valid), 1);
      check("t4_drain_data", 32'(bus.m_data), 32'('h10 + i));
      tick();
    end
    check("t4_drain_empty", 32'(bus.m_valid), 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t4_ovf_cleared", 32'(overflow), 0);

    // push and pop on a full FIFO in the same cycle: nothing is lost
    bus.m_ready = 1'b0;
    dec_updated = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec_data = 8'(8'h30 + i);
      tick();
    end
    dec_data    = 8'h34;
    bus.m_ready = 1'b1;
    tick();
    dec_updated = 1'b0;
    check("t4_full_pushpop_no_ovf", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      check("t4_full_pushpop_data", 32'(bus.m_data), 32'('h31 + i));
      tick();
    end
    check("t4_full_pushpop_empty", 32'(bus.m_valid), 0);

    // ---- 5: lock loss, no decoder reset, bytes dropped while unlocked
    dec_valid = 1'b0;
    tick();
    check("t5_link_down", 32'(link_up), 0);
    check("t5_loss_cnt", 32'(loss_cnt), 1);
    check("t5_no_dec_rst", 32'(dec_rst_n), 1);
    dec_data    = 8'h77;
    dec_updated = 1'b1;
    tick();
    dec_updated = 1'b0;
    check("t5_unlocked_byte_dropped", 32'(bus.m_valid), 0);
    check("t5_unlocked_no_ovf", 32'(overflow), 0);
    dec_valid = 1'b1;
    tick();
    check("t5_relock", 32'(link_up), 1);
    check("t5_relock_no_dec_rst", 32'(dec_rst_n), 1);

    // ---- 6: resync with buffered bytes
    bus.m_ready = 1'b0;
    dec_updated = 1'b1;
    dec_data    = 8'hA1;
    tick();
    dec_data = 8'hA2;
    tick();
    dec_updated = 1'b0;
    resync_req  = 1'b1;
    tick();
    resync_req = 1'b0;
    check("t6_resync_link_down", 32'(link_up), 0);
    check("t6_resync_dec_rst", 32'(dec_rst_n), 0);
    count_level(1'b0, 50, n, up);
    check("t6_hold_cycles", 32'(n), 4);
    check("t6_loss_unchanged", 32'(loss_cnt), 1);
    bus.m_ready = 1'b1;
    check("t6_a1_valid", 32'(bus.m_valid), 1);
    check("t6_a1_data", 32'(bus.m_data), 'hA1);
    tick();
    check("t6_a2_data", 32'(bus.m_data), 'hA2);
    tick();
    check("t6_drained", 32'(bus.m_valid), 0);
    check("t6_relocked", 32'(link_up), 1);
    resync_req = 1'b1;
    clr_status = 1'b1;
    dec_valid  = 1'b0;
    tick();
    resync_req = 1'b0;
    clr_status = 1'b0;
    check("t6_combo_dec_rst", 32'(dec_rst_n), 0);
    check("t6_combo_loss_cleared", 32'(loss_cnt), 0);
    check("t6_combo_link_down", 32'(link_up), 0);
    count_level(1'b0, 50, n, up);
    check("t6_combo_hold_cycles", 32'(n), 4);

    // ---- 3: search timeouts on an idle line, saturation
    count_level(1'b1, 1000, n, up);
    check("t3_search_cycles", 32'(n), 200);
    check("t3_timeout_cnt_1", 32'(timeout_cnt), 1);
    count_level(1'b0, 50, n, up);
    check("t3_timeout_hold_cycles", 32'(n), 4);
    for (int k = 2; k <= 300; k++) begin
      count_level(1'b1, 1000, n, up);
      count_level(1'b0, 50, n, up);
      if (k == 255) check("t3_timeout_cnt_255", 32'(timeout_cnt), 255);
    end
    check("t3_timeout_cnt_sat", 32'(timeout_cnt), 255);
    // clear on the very cycle of a timeout: the timeout still counts
    repeat (199) tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t3_clr_vs_timeout_dec_rst", 32'(dec_rst_n), 0);
    check("t3_clr_vs_timeout_cnt", 32'(timeout_cnt), 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t3_clr_plain", 32'(timeout_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
